uart_line_arbiter: RTL and testbench

UART_LINE_ARBITER -- requirements
Module: uart_line_arbiter

---
 rtl/uart_line_arbiter_pkg.sv | 16 +
 rtl/uart_line_arbiter_rr_picker.sv | 30 +++
 rtl/uart_line_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_line_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_line_arbiter_pkg.sv
// Shared definitions for the UART line arbiter: FSM state encoding, the
// line-terminating character and default parameter values.
package uart_line_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_MAX_LINE     = 128;
  localparam int unsigned DEF_IDLE_TIMEOUT = 256;

endpackage

// File: rtl/uart_line_arbiter_rr_picker.sv
// Round-robin first-one finder: returns the first set bit of req found by
// scanning upward from ptr with wrap-around.
//   req     : request vector
//   ptr     : scan start position
//   valid_c : any request set
//   pick_c  : index of the selected request (0 when none)
module rr_picker #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid_c,
  output logic [ID_W-1:0]    pick_c
);

  int unsigned idx;

  // Scan from the far end so the candidate closest to ptr wins.
  always_comb begin
    valid_c = |req;
    pick_c  = '0;
    idx     = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % NUM_REQ;
      if (req[idx]) pick_c = ID_W'(idx);
    end
  end

endmodule

// File: rtl/uart_line_arbiter.sv
// Arbitrates several character streams onto one UART output channel. A grant
// is held for a whole line and released on newline, on MAX_LINE characters,
// or after IDLE_TIMEOUT consecutive cycles without a character offered.
//   clock, reset : clock and synchronous active-low reset
//   req_valid    : per-requester character valid
//   req_ch       : per-requester character, requester i at [8i+7:8i]
//   req_ready    : per-requester character accepted
//   out_valid    : character presented to the sink
//   out_ch       : presented character
//   out_ready    : sink accepts the character
//   grant_id     : current grant holder, meaningful while locked
//   locked       : a grant is held
module uart_line_arbiter
  import uart_line_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter  int unsigned MAX_LINE     = DEF_MAX_LINE,
  parameter  int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  localparam int unsigned ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_ch,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_ch,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 locked
);

  localparam int unsigned LINE_W = $clog2(MAX_LINE + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_ch_q, out_ch_d;

  logic              pick_valid_c;
  logic [ID_W-1:0]   pick_id_c;
  logic              out_free_c;
  logic              hold_valid_c;
  logic [7:0]        hold_ch_c;
  logic              take_c;
  logic              rel_c;
  logic [7:0]        ch_arr [NUM_REQ];

  // Unpack the flat character bus so the holder's lane can be indexed.
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_lane
    assign ch_arr[i] = req_ch[8*i +: 8];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .valid_c (pick_valid_c),
    .pick_c  (pick_id_c)
  );

  assign out_free_c   = !out_valid_q || out_ready;
  assign hold_valid_c = req_valid[grant_q];
  assign hold_ch_c    = ch_arr[grant_q];

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      line_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      line_cnt_q  <= line_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  // Next-state, grant bookkeeping and output register update.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    line_cnt_d  = line_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    req_ready   = '0;
    take_c      = 1'b0;
    rel_c       = 1'b0;

    // The output register drains independently of the grant, so a character
    // buffered at release still reaches the sink.
    if (out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          grant_d = pick_id_c;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        req_ready[grant_q] = out_free_c;
        take_c             = hold_valid_c && out_free_c;
        if (take_c) begin
          out_valid_d = 1'b1;
          out_ch_d    = hold_ch_c;
          line_cnt_d  = line_cnt_q + 1'b1;
          idle_cnt_d  = '0;
          rel_c       = (hold_ch_c == CHAR_NEWLINE) ||
                        (line_cnt_d == LINE_W'(MAX_LINE));
        end else if (!hold_valid_c) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          rel_c      = (idle_cnt_d == IDLE_W'(IDLE_TIMEOUT));
        end else begin
          // Holder is offering but the sink stalls: not an idle cycle.
          idle_cnt_d = '0;
        end
        if (rel_c) begin
          state_d    = ST_IDLE;
          line_cnt_d = '0;
          idle_cnt_d = '0;
          rr_ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign grant_id  = grant_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Scoreboard bench for uart_line_arbiter: directed tests push expected
// characters and grant ids; monitors compare on each output transfer and
// each grant.
module tb_uart_line_arbiter;

  localparam int unsigned NREQ = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_ch = '0;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_ch;
  logic              out_ready = 1'b1;
  logic [1:0]        grant_id;
  logic              locked;

  logic [7:0] src_q [NREQ][$];
  logic [7:0] exp_ch [$];
  int         exp_gnt [$];
  int         checks = 0;
  int         failures = 0;
  logic       prev_locked = 1'b0;

  always #5 clock = ~clock;

  uart_line_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ch    (req_ch),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Source side: pop a character on each accepted handshake.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NREQ); i++)
        if (req_valid[i] && req_ready[i] && src_q[i].size() > 0)
          void'(src_q[i].pop_front());
    end
  end

  // Source side: present the head of each queue shortly after the falling edge.
  always @(negedge clock) begin
    #1;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_valid[i]     = (src_q[i].size() > 0);
      req_ch[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  end

  // Output monitor.
  always @(posedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_ch.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_extra actual=%0h required=none", out_ch);
      end else begin
        check("out_ch", int'(out_ch), int'(exp_ch[0]));
        void'(exp_ch.pop_front());
      end
    end
  end

  // Grant monitor: compare grant_id at every new grant.
  always @(posedge clock) begin
    if (reset && locked && !prev_locked) begin
      if (exp_gnt.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_extra actual=%0d required=none", grant_id);
      end else begin
        check("grant_order", int'(grant_id), exp_gnt[0]);
        void'(exp_gnt.pop_front());
      end
    end
    prev_locked <= locked;
  end

  task automatic push_src(input int i, input string s);
    for (int k = 0; k < s.len(); k++) src_q[i].push_back(s[k]);
  endtask

  task automatic push_exp(input string s);
    for (int k = 0; k < s.len(); k++) exp_ch.push_back(s[k]);
  endtask

  function automatic bit busy();
    bit b;
    b = locked || out_valid || (exp_ch.size() != 0);
    for (int i = 0; i < int'(NREQ); i++) if (src_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    for (int i = 0; i < int'(NREQ); i++) src_q[i].delete();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done_in_budget"}, int'(n < budget), 1);
    check({name, "_grants_left"}, exp_gnt.size(), 0);
    check({name, "_chars_left"}, exp_ch.size(), 0);
  endtask

  initial begin
    int n;
    logic [7:0] c;

    // Single requester, reset values.
    do_reset();
    check("rst_locked", int'(locked), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rr_ptr", int'(dut.rr_ptr_q), 0);
    exp_gnt.push_back(2);
    push_exp("ab\n");
    push_src(2, "ab\n");
    @(negedge clock);
    check("t1_lock_rise", int'(locked), 1);
    check("t1_grant_id", int'(grant_id), 2);
    check("t1_req_ready", int'(req_ready), 4'b0100);
    repeat (3) @(negedge clock);
    check("t1_lock_fall", int'(locked), 0);
    check("t1_last_ch", int'(out_ch), 8'h0A);
    check("t1_last_valid", int'(out_valid), 1);
    check("t1_rr_ptr", int'(dut.rr_ptr_q), 3);
    wait_done("t1", 100);

    // Fairness: everyone contends with two short lines each.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < int'(NREQ); i++) begin
        c = 8'h70 + 8'(i);
        src_q[i].push_back(c);
        src_q[i].push_back(8'h0A);
        exp_ch.push_back(c);
        exp_ch.push_back(8'h0A);
        exp_gnt.push_back(i);
      end
    wait_done("t2", 200);

    // MAX_LINE: req 1 streams 200 characters while req 2 waits.
    do_reset();
    for (int k = 0; k < 200; k++) begin
      c = 8'h41 + 8'(k % 26);
      src_q[1].push_back(c);
      if (k < 128) exp_ch.push_back(c);
    end
    push_src(2, "z\n");
    push_exp("z\n");
    for (int k = 128; k < 200; k++) exp_ch.push_back(8'h41 + 8'(k % 26));
    exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    exp_gnt.push_back(1);
    wait_done("t3", 2000);

    // Timeout: req 0 sends one character and goes quiet, req 3 waits.
    do_reset();
    push_src(0, "a");
    push_src(3, "w\n");
    push_exp("aw\n");
    exp_gnt.push_back(0);
    exp_gnt.push_back(3);
    n = 0;
    while (src_q[0].size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("t4_first_accept", int'(n < 50), 1);
    n = 0;
    while (locked && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check("t4_idle_cycles", n, 256);
    wait_done("t4", 100);

    // Back-pressure for 10 cycles mid-line.
    do_reset();
    push_src(1, "hello\n");
    push_exp("hello\n");
    exp_gnt.push_back(1);
    repeat (3) @(negedge clock);
    check("t5_pre_stall_ch", int'(out_ch), 8'h65);
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("t5_stall_ch", int'(out_ch), 8'h65);
      check("t5_stall_valid", int'(out_valid), 1);
      check("t5_stall_idle_cnt", int'(dut.idle_cnt_q), 0);
      check("t5_stall_req_ready", int'(req_ready), 0);
    end
    out_ready = 1'b1;
    wait_done("t5", 100);

    // Reset mid-line discards the buffered character and the grant.
    do_reset();
    push_src(0, "abcdef\n");
    push_src(2, "k\n");
    push_exp("abdef\nk\n");
    exp_gnt.push_back(0);
    exp_gnt.push_back(0);
    exp_gnt.push_back(2);
    repeat (4) @(negedge clock);
    check("t6_pre_rst_ch", int'(out_ch), 8'h63);
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst_out_valid", int'(out_valid), 0);
    check("t6_rst_out_ch", int'(out_ch), 0);
    check("t6_rst_locked", int'(locked), 0);
    check("t6_rst_grant_id", int'(grant_id), 0);
    check("t6_rst_req_ready", int'(req_ready), 0);
    check("t6_rst_rr_ptr", int'(dut.rr_ptr_q), 0);
    check("t6_rst_line_cnt", int'(dut.line_cnt_q), 0);
    reset = 1'b1;
    wait_done("t6", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
